// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between a binary producer and the bin2bcd_seq converter.
interface bin2bcd_seq_if #(
    parameter int N_BIN = 16,
    parameter int N_DIG = 5
);
    logic                 init;
    logic [N_BIN-1:0]     bin_in;
    logic [4*N_DIG-1:0]   bcd_out;
    logic                 busy;
    logic                 done;

    modport master (output init, bin_in, input bcd_out, busy, done);
    modport slave  (input init, bin_in, output bcd_out, busy, done);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per ADD3+SHIFT pair,
// result latched on completion and done held for DONE_HOLD cycles.
module bin2bcd_seq #(
    parameter int N_BIN     = 16,
    parameter int N_DIG     = 5,
    parameter int DONE_HOLD = 50
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int BCD_W   = 4 * N_DIG;
    localparam int CNT_MAX = (N_BIN > DONE_HOLD) ? N_BIN : DONE_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD3  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [N_BIN-1:0]   bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               busy, done;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign bus.bcd_out = bcd_out_q;
    assign bus.busy    = busy;
    assign bus.done    = done;

    always_comb begin
        state_d   = state_q;
        bin_sr_d  = bin_sr_q;
        bcd_sr_d  = bcd_sr_q;
        bcd_out_d = bcd_out_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.init) state_d = LOAD;
            end
            LOAD: begin
                busy     = 1'b1;
                bin_sr_d = bus.bin_in;
                bcd_sr_d = '0;
                cnt_d    = '0;
                state_d  = ADD3;
            end
            ADD3: begin
                busy = 1'b1;
                // Digits never exceed 9 here, so +3 stays within the nibble.
                for (int i = 0; i < N_DIG; i++) begin
                    if (bcd_sr_q[4*i +: 4] >= 4'd5)
                        bcd_sr_d[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                {bcd_sr_d, bin_sr_d} = {bcd_sr_q[BCD_W-2:0], bin_sr_q, 1'b0};
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(N_BIN)) begin
                    bcd_out_d = {bcd_sr_q[BCD_W-2:0], bin_sr_q[N_BIN-1]};
                    cnt_d     = '0;
                    state_d   = DONE;
                end else begin
                    state_d = ADD3;
                end
            end
            DONE: begin
                done  = 1'b1;
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_W'(DONE_HOLD)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_sr_q  <= '0;
            bcd_sr_q  <= '0;
            bcd_out_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bin_sr_q  <= bin_sr_d;
            bcd_sr_q  <= bcd_sr_d;
            bcd_out_q <= bcd_out_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule
